// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and link constants
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 435;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter with load and terminal-count pulse
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 435
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Load,
    input  logic i_En,
    output logic o_Tc
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] count;

    assign o_Tc = i_En && (count == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge i_Clock) begin
        if (i_Reset || i_Load) begin
            count <= '0;
        end else if (i_En) begin
            count <= o_Tc ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_buf.sv
// rtl/uart_tx_buf.sv - buffered 8N1/8N2 UART transmitter; UART_TX_PARITY_EN adds an even-parity bit
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Ready,
    output logic       o_Tx_Active,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Done
);

    uart_state_e state, state_next;
    logic [7:0]  shift_q, shift_next;
    logic [7:0]  hold_q, hold_next;
    logic        hold_full_q, hold_full_next;
    logic [2:0]  bit_idx_q, bit_idx_next;
    logic        serial_next;
    logic        done_next;
    logic        bit_tc;
    logic        accept;
    logic        stop_end;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .i_Clock(i_Clock),
        .i_Reset(i_Reset),
        .i_Load (state == ST_IDLE),
        .i_En   (state != ST_IDLE),
        .o_Tc   (bit_tc)
    );

    assign o_Tx_Ready  = !hold_full_q;
    assign o_Tx_Active = (state != ST_IDLE);
    assign accept      = i_Tx_DV && o_Tx_Ready;
    assign stop_end    = (state == ST_STOP) && bit_tc && (bit_idx_q == 3'(STOP_BITS - 1));

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state       <= ST_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bit_idx_q   <= '0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Done   <= 1'b0;
        end else begin
            state       <= state_next;
            shift_q     <= shift_next;
            hold_q      <= hold_next;
            hold_full_q <= hold_full_next;
            bit_idx_q   <= bit_idx_next;
            o_Tx_Serial <= serial_next;
            o_Tx_Done   <= done_next;
        end
    end

    always_comb begin
        state_next     = state;
        shift_next     = shift_q;
        hold_next      = hold_q;
        hold_full_next = hold_full_q;
        bit_idx_next   = bit_idx_q;
        done_next      = 1'b0;
        serial_next    = 1'b1;

        // A byte offered on the final stop clock bypasses the holding register
        if (accept && (state != ST_IDLE) && !stop_end) begin
            hold_next      = i_Tx_Byte;
            hold_full_next = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    shift_next   = i_Tx_Byte;
                    bit_idx_next = '0;
                    state_next   = ST_START;
                end
            end
            ST_START: begin
                if (bit_tc) begin
                    bit_idx_next = '0;
                    state_next   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tc) begin
                    if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
                        bit_idx_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next   = ST_PARITY;
`else
                        state_next   = ST_STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_tc) begin
                    bit_idx_next = '0;
                    state_next   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (stop_end) begin
                    done_next    = 1'b1;
                    bit_idx_next = '0;
                    if (hold_full_q) begin
                        shift_next     = hold_q;
                        hold_full_next = 1'b0;
                        state_next     = ST_START;
                    end else if (i_Tx_DV) begin
                        shift_next = i_Tx_Byte;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (bit_tc) begin
                    bit_idx_next = bit_idx_q + 3'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // The line register follows the state being entered, so it changes on the transition edge
        case (state_next)
            ST_START:  serial_next = 1'b0;
            ST_DATA:   serial_next = shift_next[bit_idx_next];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: serial_next = ^shift_next;
`endif
            default:   serial_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb/tb_uart_tx_buf.sv - scoreboard bench for uart_tx_buf with a line-sampling monitor
module tb_uart_tx_buf;

    localparam int CPB = 4;
    localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB  = 10 + PAR + (SB - 1);
    localparam int FL  = NB * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dv = 1'b0;
    logic [7:0] din = 8'h00;
    logic       o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic [7:0] exp_q[$];

    uart_tx_buf #(
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (SB)
    ) dut (
        .i_Clock    (clk),
        .i_Reset    (rst),
        .i_Tx_DV    (dv),
        .i_Tx_Byte  (din),
        .o_Tx_Ready (o_Tx_Ready),
        .o_Tx_Active(o_Tx_Active),
        .o_Tx_Serial(o_Tx_Serial),
        .o_Tx_Done  (o_Tx_Done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NB-1:0] frame_of(input logic [7:0] b);
        logic [NB-1:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = b;
        if (PAR == 1) f[9] = ^b;
        return f;
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // Monitor: records each frame at the line and compares it with the next queued byte
    logic        in_frame = 1'b0;
    int          off = 0;
    logic        done_due = 1'b0;
    logic [FL-1:0] samp;

    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
            off      = 0;
            done_due = 1'b0;
        end else begin
            if (done_due) begin
                check("done_pulse", int'(o_Tx_Done), 1);
                done_due = 1'b0;
            end else if (o_Tx_Done) begin
                check("done_spurious", 1, 0);
            end
            if (!in_frame && !o_Tx_Serial) begin
                in_frame = 1'b1;
                off      = 0;
            end
            if (in_frame) begin
                samp[off] = o_Tx_Serial;
                off++;
                if (off == FL) begin
                    logic [NB-1:0] f;
                    logic [7:0]    got, want;
                    int            bad;
                    in_frame = 1'b0;
                    done_due = 1'b1;
                    for (int k = 0; k < 8; k++) got[k] = samp[(k + 1) * CPB + 1];
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL frame_unexpected got %02h want none", got);
                    end else begin
                        want = exp_q.pop_front();
                        f    = frame_of(want);
                        bad  = 0;
                        for (int k = 0; k < FL; k++) if (samp[k] != f[k / CPB]) bad++;
                        if (bad != 0) begin
                            errors++;
                            $display("FAIL frame got %02h want %02h (%0d bad samples)", got, want, bad);
                        end
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int g;
        g = 0;
        while (!o_Tx_Ready && g < 1000) begin
            tick(1);
            g++;
        end
        check("send_ready", int'(o_Tx_Ready), 1);
        dv  = 1'b1;
        din = b;
        @(posedge clk);
        exp_q.push_back(b);
        #1;
        acc_cyc = cyc;
        dv  = 1'b0;
        din = 8'hxx;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || o_Tx_Active) && g < 2000) begin
            tick(1);
            g++;
        end
        check("drain_timeout", g, (g < 2000) ? g : 0);
        tick(3);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_serial"}, int'(o_Tx_Serial), 1);
        check({tag, "_ready"},  int'(o_Tx_Ready), 1);
        check({tag, "_active"}, int'(o_Tx_Active), 0);
        check({tag, "_done"},   int'(o_Tx_Done), 0);
    endtask

    initial begin
        int g;
        int a0;
        tick(3);
        check_reset_outputs("rst");
        rst = 1'b0;
        tick(2);

        // Single byte: start bit on the accept edge, done 40 clocks later
        send(8'hA5);
        check("start_latency", int'(o_Tx_Serial), 0);
        a0 = acc_cyc;
        g  = 0;
        while (!o_Tx_Done && g < 200) begin
            tick(1);
            g++;
        end
        check("done_latency", cyc - a0, 10 * CPB);
        drain();

        // Back-to-back: second byte held during DATA, no gap between frames
        send(8'h00);
        a0 = acc_cyc;
        tick(12);
        send(8'hFF);
        check("hold_ready_low", int'(o_Tx_Ready), 0);
        g = 0;
        while (!o_Tx_Ready && g < 200) begin
            tick(1);
            g++;
        end
        check("hold_ready_rise", cyc - a0, 10 * CPB);
        check("b2b_second_start", int'(o_Tx_Serial), 0);
        g = 0;
        while (o_Tx_Active && g < 400) begin
            tick(1);
            g++;
        end
        check("b2b_active_span", cyc - a0, 20 * CPB);
        drain();

        // Overflow: a strobe while the holding register is full is dropped
        send(8'h11);
        tick(5);
        send(8'h22);
        check("ovf_ready_low", int'(o_Tx_Ready), 0);
        dv  = 1'b1;
        din = 8'h33;
        tick(1);
        dv  = 1'b0;
        drain();

        // Reset during data bit 3 aborts the frame
        send(8'h5A);
        tick(4 * CPB);
        rst = 1'b1;
        exp_q.delete();
        tick(1);
        check_reset_outputs("midrst");
        rst = 1'b0;
        tick(2);
        send(8'h3C);
        drain();

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
